// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings, FSM states, sizes.
// Optional MDU_MADD_EN enables madd/msub (ops 110/111) as iterative accumulate ops.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;
  localparam int MDU_ITER  = MDU_WIDTH;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_MADD  = 3'b110,
    OP_MSUB  = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  typedef logic [2*MDU_WIDTH-1:0] prod_t;

  function automatic logic is_iter_op(input logic [2:0] op);
`ifdef MDU_MADD_EN
    return (op != OP_MTHI) && (op != OP_MTLO);
`else
    return (op[2] == 1'b0);
`endif
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One iteration of the MDU datapath: shift-add multiply step or restoring shift-subtract divide step.
// For divide, the new quotient bit is shifted into the low half (lo_next[0]).
module mdu_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rs;
  logic [WIDTH:0] diff;

  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    rs      = {hi, lo[WIDTH-1]};
    diff    = rs - {1'b0, opnd};
    hi_next = sum[WIDTH:1];
    lo_next = {sum[0], lo[WIDTH-1:1]};
    if (is_div) begin
      // rs < 2*divisor always holds, so diff[WIDTH] is a clean borrow flag
      if (!diff[WIDTH]) begin
        hi_next = diff[WIDTH-1:0];
        lo_next = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_next = rs[WIDTH-1:0];
        lo_next = {lo[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Multi-cycle multiply/divide unit with HI/LO registers and a Start/Busy handshake.
// Define MDU_MADD_EN to make ops 110/111 (madd/msub) accumulate into {HI,LO}.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       MDUOp,
  input  logic             Start,
  output logic             Busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CNT_W = $clog2(ITER + 1);

  state_e           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  mdu_op_e          op_reg;
  logic [WIDTH-1:0] acc_hi_reg, acc_lo_reg, opnd_reg;
  logic [WIDTH-1:0] hi_reg, lo_reg;
  logic             neg_q_reg, neg_r_reg, div_zero_reg;

  logic             accept;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [2*WIDTH-1:0] prod, prod_s, fix_hilo;
  logic             fix_we;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: if (Start && is_iter_op(MDUOp)) begin
        accept     = 1'b1;
        state_next = RUN;
      end
      RUN:  if (cnt_reg == CNT_W'(ITER - 1)) state_next = FIX;
      FIX:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign Busy = (state_reg != IDLE);
  assign HI   = hi_reg;
  assign LO   = lo_reg;

  always_comb begin
    a_neg = is_signed_op(MDUOp) && A[WIDTH-1];
    b_neg = is_signed_op(MDUOp) && B[WIDTH-1];
    a_abs = a_neg ? -A : A;
    b_abs = b_neg ? -B : B;
  end

  mdu_iter_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div_op(op_reg)),
    .hi      (acc_hi_reg),
    .lo      (acc_lo_reg),
    .opnd    (opnd_reg),
    .hi_next (step_hi),
    .lo_next (step_lo)
  );

  // HI/LO cannot change while busy, so the live registers equal the E0 snapshot for madd/msub
  always_comb begin
    prod     = {acc_hi_reg, acc_lo_reg};
    prod_s   = neg_q_reg ? -prod : prod;
    fix_hilo = {hi_reg, lo_reg};
    fix_we   = !div_zero_reg;
    case (op_reg)
      OP_MULT, OP_MULTU: fix_hilo = prod_s;
      OP_DIV, OP_DIVU: begin
        fix_hilo[WIDTH-1:0]       = neg_q_reg ? -acc_lo_reg : acc_lo_reg;
        fix_hilo[2*WIDTH-1:WIDTH] = neg_r_reg ? -acc_hi_reg : acc_hi_reg;
      end
`ifdef MDU_MADD_EN
      OP_MADD: fix_hilo = {hi_reg, lo_reg} + prod_s;
      OP_MSUB: fix_hilo = {hi_reg, lo_reg} - prod_s;
`endif
      default: fix_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg      <= '0;
      op_reg       <= OP_MULT;
      acc_hi_reg   <= '0;
      acc_lo_reg   <= '0;
      opnd_reg     <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            op_reg       <= mdu_op_e'(MDUOp);
            cnt_reg      <= '0;
            acc_hi_reg   <= '0;
            neg_q_reg    <= a_neg ^ b_neg;
            neg_r_reg    <= a_neg;
            div_zero_reg <= is_div_op(MDUOp) && (B == '0);
            // divide iterates on the dividend; multiply walks the multiplier bits
            if (is_div_op(MDUOp)) begin
              acc_lo_reg <= a_abs;
              opnd_reg   <= b_abs;
            end else begin
              acc_lo_reg <= b_abs;
              opnd_reg   <= a_abs;
            end
          end else if (Start && MDUOp == OP_MTHI) begin
            hi_reg <= A;
          end else if (Start && MDUOp == OP_MTLO) begin
            lo_reg <= A;
          end
        end
        RUN: begin
          acc_hi_reg <= step_hi;
          acc_lo_reg <= step_lo;
          cnt_reg    <= cnt_reg + 1'b1;
        end
        FIX: begin
          cnt_reg <= '0;
          if (fix_we) begin
            hi_reg <= fix_hilo[2*WIDTH-1:WIDTH];
            lo_reg <= fix_hilo[WIDTH-1:0];
          end
        end
        default: cnt_reg <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed testbench for mdu_iter: hand-computed HI/LO results, Busy duration and handshake corner cases.
// Build with +define+MDU_MADD_EN to exercise the madd/msub branch.
module tb_mdu_iter;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] A = '0, B = '0;
  logic [2:0]  MDUOp = 3'b000;
  logic        Start = 1'b0;
  logic        Busy;
  logic [31:0] HI, LO;

  int checks = 0;
  int failures = 0;
  int cyc;

  mdu_iter dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .B     (B),
    .MDUOp (MDUOp),
    .Start (Start),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s value=%h", tag, got);
    end
  endtask

  // Called at a negedge; pulses Start for one edge, scrambles inputs, counts Busy cycles.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int n);
    MDUOp = op; A = a; B = b; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    A = 32'h5A5A5A5A; B = 32'h0; MDUOp = 3'b100;
    n = 0;
    while (Busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_hi_lo", {HI, LO}, 64'h0);
    check("reset_busy", {63'h0, Busy}, 64'h0);
    reset = 1'b1;
    @(negedge clk);

    run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc);
    check("multu_busy_cycles", 64'(cyc), 64'(MDU_ITER + 1));
    check("multu_max", {HI, LO}, 64'hFFFFFFFE_00000001);

    run_op(3'b000, 32'hFFFFFFF9, 32'd3, cyc);
    check("mult_neg7x3", {HI, LO}, 64'hFFFFFFFF_FFFFFFEB);

    run_op(3'b000, 32'hFFFFFFFD, 32'hFFFFFFFC, cyc);
    check("mult_neg3xneg4", {HI, LO}, 64'h0_0000000C);

    run_op(3'b010, 32'hFFFFFFF9, 32'd2, cyc);
    check("div_neg7_2", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);

    run_op(3'b010, 32'd7, 32'hFFFFFFFE, cyc);
    check("div_7_neg2", {HI, LO}, 64'h00000001_FFFFFFFD);

    run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, cyc);
    check("div_min_neg1", {HI, LO}, 64'h00000000_80000000);

    run_op(3'b011, 32'd100, 32'd7, cyc);
    check("divu_100_7", {HI, LO}, 64'h00000002_0000000E);

    // divide by zero: full timing, HI/LO untouched
    run_op(3'b100, 32'd5, 32'd0, cyc);
    run_op(3'b101, 32'd6, 32'd0, cyc);
    run_op(3'b011, 32'd100, 32'd0, cyc);
    check("divu_zero_cycles", 64'(cyc), 64'(MDU_ITER + 1));
    check("divu_zero_keep", {HI, LO}, 64'h00000005_00000006);

    run_op(3'b101, 32'hDEADBEEF, 32'd0, cyc);
    check("mtlo_busy", 64'(cyc), 64'h0);
    check("mtlo_value", {HI, LO}, 64'h00000005_DEADBEEF);

    // back-to-back: second Start lands on the first edge after Busy falls
    run_op(3'b001, 32'd3, 32'd5, cyc);
    run_op(3'b001, 32'd3, 32'd5, cyc);
    check("b2b_cycles", 64'(cyc), 64'(MDU_ITER + 1));
    check("b2b_multu", {HI, LO}, 64'h0_0000000F);

    // mthi during RUN is ignored; reset mid-RUN aborts
    run_op(3'b100, 32'hAAAA, 32'd0, cyc);
    MDUOp = 3'b011; A = 32'd100; B = 32'd7; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (9) @(negedge clk);
    MDUOp = 3'b100; A = 32'h1234; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    check("mthi_while_busy", {HI, 31'h0, Busy}, {32'h0000AAAA, 32'h1});
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_regs", {HI, LO}, 64'h0);
    check("abort_busy", {63'h0, Busy}, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("after_abort_idle", {31'h0, Busy, HI, LO[31:0]} , 64'h0);

    run_op(3'b100, 32'd0, 32'd0, cyc);
    run_op(3'b101, 32'd10, 32'd0, cyc);
    run_op(3'b110, 32'hFFFFFFFE, 32'd3, cyc);
`ifdef MDU_MADD_EN
    check("madd_cycles", 64'(cyc), 64'(MDU_ITER + 1));
    check("madd_value", {HI, LO}, 64'h0_00000004);
    run_op(3'b111, 32'hFFFFFFFE, 32'd3, cyc);
    check("msub_value", {HI, LO}, 64'h0_0000000A);
`else
    check("madd_noop_busy", 64'(cyc), 64'h0);
    check("madd_noop_value", {HI, LO}, 64'h0_0000000A);
    run_op(3'b111, 32'hFFFFFFFE, 32'd3, cyc);
    check("msub_noop_value", {HI, LO}, 64'h0_0000000A);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Multi-cycle multiply/divide unit that sits beside the single-cycle ALU in EX.
- Accepts operands with an op code on a Start pulse, holds Busy while iterating, and writes the HI/LO registers on completion.
- It is the multi-cycle partner of the ALU: the ALU answers combinationally, while this block answers through a Start/Busy handshake back to the stall logic.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- ITER, WIDTH, number of iteration cycles (one bit per cycle).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- A  input  WIDTH  rs operand (multiplicand/dividend, or mthi/mtlo source).
- B  input  WIDTH  rt operand (multiplier/divisor).
- MDUOp  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110 madd, 111 msub.
- Start  input  1  request, sampled only when Busy=0.
- Busy  output  1  high while an iterative op is in flight.
- HI  output  WIDTH  HI register.
- LO  output  WIDTH  LO register.

Behaviour:
- Reset (async, reset=0): HI=0, LO=0, Busy=0, state IDLE, iteration counter 0.
- States:
  - IDLE --(Start & iterative op)--> RUN.
  - RUN --(counter==ITER-1)--> FIX.
  - FIX --> IDLE.
- Accept edge E0 (Start=1, Busy=0, op 000-011): latch |A|, |B| (signed ops) or raw A, B (unsigned ops); latch result signs; Busy=1 from E0.
- RUN: one shift-add (multiply) or one restoring shift-subtract (divide) step per edge, E1..E32.
- FIX at E33: apply sign correction, write HI/LO, Busy=0. Busy is high for exactly 33 cycles; a new Start is accepted at E33+1.
- mult/multu: {HI,LO} = 64-bit product.
- div/divu: LO = quotient, HI = remainder.
  - Signed: quotient truncates toward zero; remainder takes the sign of the dividend.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divisor zero: full 33-cycle timing still runs; HI and LO are left unchanged.
- mthi/mtlo: with Start=1, Busy=0, HI (or LO) = A at that edge; Busy stays 0.
- Start while Busy=1: ignored entirely; A, B and MDUOp changes during RUN are ignored.
- HI/LO never show partial results; they change only at FIX or on an mthi/mtlo edge.
- reset asserted mid-RUN: immediate abort to the reset values; the in-flight op is lost.

Optional Feature:
- MDU_MADD_EN defined: 110 madd gives {HI,LO} += signed A*B; 111 msub gives {HI,LO} -= signed A*B.
  - Same 33-cycle timing; the accumulate happens in FIX using the {HI,LO} value sampled at E0.
- MDU_MADD_EN undefined: ops 110/111 are no-ops; Busy stays 0 and HI/LO are unchanged.

Decomposition:
- Shared package mdu_pkg holds:
  - the MDUOp encodings;
  - the state enum IDLE/RUN/FIX;
  - ITER;
  - the 64-bit product type.
- One natural sub-module, mdu_iter_step: a combinational single-iteration datapath (select add-shift vs. subtract-restore, returning next partial remainder/product and quotient bit).
- FSM, counter and sign fix stay in mdu_iter.

Test Plan:
- multu A=0xFFFFFFFF, B=0xFFFFFFFF -> Busy high 33 cycles, then HI=0xFFFFFFFE, LO=0x00000001.
- mult A=-7 (0xFFFFFFF9), B=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; div A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- div A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0; divu A=100, B=0 with prior HI=5, LO=6 -> after 33 cycles HI=5, LO=6.
- Start divu 100/7, pulse Start with mthi A=0x1234 at cycle 10, then pulse reset low at cycle 20 -> mthi ignored; after reset HI=LO=0, Busy=0.
- mtlo A=0xDEADBEEF with Busy=0 -> LO=0xDEADBEEF next edge, Busy never rises; back-to-back multu 3*5 started at the E33+1 edge -> accepted, LO=15.
- MDU_MADD_EN: HI=0, LO=10, madd A=-2, B=3 -> HI=0, LO=4. Same stimulus without the macro -> Busy stays 0, HI=0, LO=10.
